// File: rtl/matmul_result_streamer.sv
// matmul_result_streamer
//   Snapshots the parallel result matrix C (and per-element scales S_C) of the
//   systolic matmul array a fixed number of edges after a launch pulse, then
//   streams it row-major, one element per valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             one-cycle launch pulse (operands entering the array)
//   C_in, S_C_in        parallel result matrix and scales
//   o_busy              high while waiting for the result or streaming it
//   o_valid, i_ready    stream handshake
//   o_data, o_scale     current element and its scale (0 when not valid)
//   o_row, o_col        tags of the current element (0 when not valid)
//   o_last              current element is the final one (x_rows-1, y_cols-1)
//   o_done              one-cycle pulse after the final handshake
module matmul_result_streamer #(
   parameter int unsigned x_rows      = 4,
   parameter int unsigned y_cols      = 4,
   parameter int unsigned out_width   = 8,
   parameter int unsigned scale_width = 8,
   parameter int unsigned latency     = 2,
   localparam int unsigned RowW       = (x_rows > 1) ? $clog2(x_rows) : 1,
   localparam int unsigned ColW       = (y_cols > 1) ? $clog2(y_cols) : 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_start,
   input  logic signed [out_width-1:0]   C_in   [x_rows][y_cols],
   input  logic        [scale_width-1:0] S_C_in [x_rows][y_cols],
   output logic                          o_busy,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic signed [out_width-1:0]   o_data,
   output logic        [scale_width-1:0] o_scale,
   output logic        [RowW-1:0]        o_row,
   output logic        [ColW-1:0]        o_col,
   output logic                          o_last,
   output logic                          o_done
);

   // Counter only ever holds latency-1 down to 0.
   localparam int unsigned CntW = (latency > 1) ? $clog2(latency) : 1;
   localparam logic [CntW-1:0] CntInit = CntW'(latency - 1);
   localparam logic [RowW-1:0] LastRow = RowW'(x_rows - 1);
   localparam logic [ColW-1:0] LastCol = ColW'(y_cols - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;

   logic [1:0]                    r_state;
   logic [CntW-1:0]               r_cnt;
   logic [RowW-1:0]               r_row;
   logic [ColW-1:0]               r_col;
   logic                          r_done;
   logic signed [out_width-1:0]   r_snap_c [x_rows][y_cols];
   logic        [scale_width-1:0] r_snap_s [x_rows][y_cols];

   logic w_valid;
   logic w_last;
   logic w_hs;

   assign w_valid = (r_state == ST_STREAM);
   assign w_last  = w_valid && (r_row == LastRow) && (r_col == LastCol);
   assign w_hs    = w_valid && i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_done  <= 1'b0;
         for (int r = 0; r < int'(x_rows); r++) begin
            for (int c = 0; c < int'(y_cols); c++) begin
               r_snap_c[r][c] <= '0;
               r_snap_s[r][c] <= '0;
            end
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_WAIT;
                  r_cnt   <= CntInit;
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_snap_c <= C_in;
                  r_snap_s <= S_C_in;
                  r_row    <= '0;
                  r_col    <= '0;
                  r_state  <= ST_STREAM;
               end else begin
                  r_cnt <= r_cnt - CntW'(1);
               end
            end
            ST_STREAM: begin
               if (w_hs) begin
                  if (w_last) begin
                     r_done <= 1'b1;
                     r_row  <= '0;
                     r_col  <= '0;
                     // A launch coinciding with the final handshake is honoured;
                     // the old snapshot stays until the new capture.
                     if (i_start) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CntInit;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end else if (r_col == LastCol) begin
                     r_col <= '0;
                     r_row <= r_row + RowW'(1);
                  end else begin
                     r_col <= r_col + ColW'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Outputs are decoded from state so an asynchronous reset clears them at once.
   always_comb begin
      o_busy  = (r_state == ST_WAIT) || (r_state == ST_STREAM);
      o_valid = w_valid;
      o_done  = r_done;
      o_last  = w_last;
      o_data  = '0;
      o_scale = '0;
      o_row   = '0;
      o_col   = '0;
      if (w_valid) begin
         o_data  = r_snap_c[r_row][r_col];
         o_scale = r_snap_s[r_row][r_col];
         o_row   = r_row;
         o_col   = r_col;
      end
   end

endmodule

// File: tb/tb_matmul_result_streamer.sv
module tb_matmul_result_streamer;

   localparam int XR  = 4;
   localparam int YC  = 4;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Main instance (default parameters)
   logic              i_start, i_ready;
   logic signed [7:0] c_in [XR][YC];
   logic        [7:0] s_in [XR][YC];
   logic              o_busy, o_valid, o_last, o_done;
   logic signed [7:0] o_data;
   logic        [7:0] o_scale;
   logic        [1:0] o_row, o_col;

   matmul_result_streamer #(
      .x_rows(XR), .y_cols(YC), .out_width(8), .scale_width(8), .latency(LAT)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .C_in(c_in), .S_C_in(s_in),
      .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
      .o_scale(o_scale), .o_row(o_row), .o_col(o_col), .o_last(o_last), .o_done(o_done)
   );

   // Corner instance: 1x3, latency 1
   logic              start2, ready2;
   logic signed [7:0] c2 [1][3];
   logic        [7:0] s2 [1][3];
   logic              busy2, valid2, last2, done2;
   logic signed [7:0] data2;
   logic        [7:0] scale2;
   logic        [0:0] row2;
   logic        [1:0] col2;

   matmul_result_streamer #(
      .x_rows(1), .y_cols(3), .out_width(8), .scale_width(8), .latency(1)
   ) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .C_in(c2), .S_C_in(s2),
      .o_busy(busy2), .o_valid(valid2), .i_ready(ready2), .o_data(data2),
      .o_scale(scale2), .o_row(row2), .o_col(col2), .o_last(last2), .o_done(done2)
   );

   typedef struct {
      logic signed [7:0] d;
      logic        [7:0] s;
      logic        [1:0] r;
      logic        [1:0] c;
      logic              last;
   } item_t;

   item_t exp_q[$];
   int    checks     = 0;
   int    failures   = 0;
   int    pops       = 0;
   int    ready_mode = 0;
   int    ready_ph   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: element stream is the held matrix, row-major.
   task automatic push_expected();
      for (int r = 0; r < XR; r++) begin
         for (int c = 0; c < YC; c++) begin
            exp_q.push_back('{d: c_in[r][c], s: s_in[r][c], r: 2'(r), c: 2'(c),
                              last: (r == XR - 1 && c == YC - 1)});
         end
      end
   endtask

   task automatic fill_random();
      for (int r = 0; r < XR; r++) begin
         for (int c = 0; c < YC; c++) begin
            c_in[r][c] = 8'($urandom);
            s_in[r][c] = 8'($urandom);
         end
      end
   endtask

   task automatic scramble();
      for (int r = 0; r < XR; r++) begin
         for (int c = 0; c < YC; c++) begin
            c_in[r][c] = 8'h7F;
            s_in[r][c] = 8'hFF;
         end
      end
   endtask

   // Called just after the edge that sampled i_start.
   task automatic after_start();
      @(negedge clk);
      check("wait_busy", o_busy, 1);
      check("wait_not_valid", o_valid, 0);
      for (int k = 1; k <= LAT; k++) begin
         @(posedge clk);
         #1;
         check("first_valid_latency", o_valid, (k == LAT));
      end
      scramble();
   endtask

   task automatic run_burst();
      push_expected();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      after_start();
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         tick();
         n++;
      end
      check("drain_remaining", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      check("idle_after_burst", o_busy, 0);
   endtask

   // Downstream readiness patterns
   initial begin
      i_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = (ready_ph % 4 == 0) || (ready_ph % 4 == 3);
            default: i_ready = 1'($urandom_range(0, 1));
         endcase
         ready_ph++;
      end
   end

   // Monitor / scoreboard for the main instance
   initial begin
      logic        prev_hs_last = 1'b0;
      logic        prev_stall   = 1'b0;
      logic [31:0] saved        = '0;
      item_t       it;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_hs_last = 1'b0;
            prev_stall   = 1'b0;
         end else begin
            check("done_pulse", o_done, prev_hs_last);
            if (!o_valid) check("zero_when_invalid", {o_data, o_scale, o_row, o_col, o_last}, 0);
            if (prev_stall) begin
               check("stall_hold", {o_valid, o_data, o_scale, o_row, o_col, o_last}, saved);
            end
            prev_hs_last = 1'b0;
            prev_stall   = 1'b0;
            if (o_valid && i_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_element: got row %0d col %0d expected none",
                           o_row, o_col);
               end else begin
                  it = exp_q.pop_front();
                  check("elem_data", o_data, it.d);
                  check("elem_scale", o_scale, it.s);
                  check("elem_row", o_row, it.r);
                  check("elem_col", o_col, it.c);
                  check("elem_last", o_last, it.last);
                  prev_hs_last = it.last;
                  pops++;
               end
            end else if (o_valid) begin
               prev_stall = 1'b1;
               saved      = {11'd0, o_valid, o_data, o_scale, o_row, o_col, o_last};
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic signed [7:0] e_d [3];
      logic        [7:0] e_s [3];
      int                base;
      int                n;

      rst_n   = 1'b0;
      i_start = 1'b0;
      start2  = 1'b0;
      ready2  = 1'b1;
      fill_random();
      for (int c = 0; c < 3; c++) begin
         c2[0][c] = 8'd0;
         s2[0][c] = 8'd0;
      end
      #1;
      check("reset_busy", o_busy, 0);
      check("reset_valid", o_valid, 0);
      check("reset_done", o_done, 0);
      check("reset_outputs", {o_data, o_scale, o_row, o_col, o_last}, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Basic stream
      ready_mode = 0;
      for (int r = 0; r < XR; r++) begin
         for (int c = 0; c < YC; c++) begin
            c_in[r][c] = 8'(r * 4 + c);
            s_in[r][c] = 8'(8'h80 + r);
         end
      end
      repeat (5) tick();
      run_burst();
      wait_drain();

      // Backpressure 1,0,0,1
      ready_mode = 1;
      fill_random();
      run_burst();
      wait_drain();

      // Snapshot isolation and signedness, random backpressure
      ready_mode = 2;
      fill_random();
      c_in[0][0] = -8'sd128;
      run_burst();
      wait_drain();

      // i_start during STREAM is ignored
      ready_mode = 0;
      fill_random();
      run_burst();
      repeat (3) tick();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      wait_drain();

      // i_start on the final-handshake cycle
      fill_random();
      run_burst();
      n = 0;
      while (!(o_valid && o_last) && n < 100) begin
         tick();
         n++;
      end
      check("found_last", o_valid && o_last, 1);
      fill_random();
      push_expected();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      after_start();
      wait_drain();

      // Reset mid-stream
      ready_mode = 2;
      fill_random();
      base = pops;
      run_burst();
      n = 0;
      while (pops < base + 5 && n < 200) begin
         tick();
         n++;
      end
      check("reached_elem5", pops - base, 5);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_busy", o_busy, 0);
      check("rst_valid", o_valid, 0);
      check("rst_done", o_done, 0);
      check("rst_outputs", {o_data, o_scale, o_row, o_col, o_last}, 0);
      exp_q.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("rst_stays_idle", o_busy, 0);
      fill_random();
      run_burst();
      wait_drain();

      // Parameter corner: 1x3, latency 1
      for (int c = 0; c < 3; c++) begin
         c2[0][c] = 8'($urandom);
         s2[0][c] = 8'($urandom);
         e_d[c]   = c2[0][c];
         e_s[c]   = s2[0][c];
      end
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      @(negedge clk);
      check("corner_wait_valid", valid2, 0);
      check("corner_wait_busy", busy2, 1);
      @(posedge clk);
      #1;
      check("corner_first_valid", valid2, 1);
      for (int c = 0; c < 3; c++) begin
         c2[0][c] = 8'h7F;
         s2[0][c] = 8'hFF;
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("corner_data", data2, e_d[c]);
         check("corner_scale", scale2, e_s[c]);
         check("corner_row", row2, 0);
         check("corner_col", col2, c);
         check("corner_last", last2, (c == 2));
         check("corner_no_done", done2, 0);
      end
      @(negedge clk);
      check("corner_done", done2, 1);
      check("corner_idle", {busy2, valid2}, 0);
      @(negedge clk);
      check("corner_done_once", done2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/matmul_result_streamer.md
Name: matmul_result_streamer

Overview:
- Output-side companion to the integer MX systolic matmul array.
- The array presents the whole result matrix C, plus per-element scales S_C, in parallel.
- This block snapshots that result a fixed number of cycles after a launch pulse, then transmits it one element per handshake over a valid/ready stream.
- The stream is row-major, with row/col tags and a last flag, for consumption by a writer or DMA.

Parameters:
- x_rows, 4, result rows (≥1)
- y_cols, 4, result columns (≥1)
- out_width, 8, bit width of each signed C element
- scale_width, 8, bit width of each unsigned scale
- latency, 2, edges from i_start sample to valid C_in/S_C_in (≥1)

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_start  input  1  one-cycle launch pulse, coincident with operands entering the matmul array
- C_in  input  signed [out_width-1:0] [x_rows][y_cols]  parallel result matrix
- S_C_in  input  [scale_width-1:0] [x_rows][y_cols]  parallel result scales
- o_busy  output  1  high in WAIT or STREAM
- o_valid  output  1  stream element valid
- i_ready  input  1  downstream accepts element
- o_data  output  signed [out_width-1:0]  current C element
- o_scale  output  [scale_width-1:0]  current scale
- o_row  output  $clog2(x_rows) (min 1)  row index of current element
- o_col  output  $clog2(y_cols) (min 1)  column index of current element
- o_last  output  1  current element is (x_rows-1, y_cols-1)
- o_done  output  1  one-cycle pulse, the cycle after the final handshake

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; latency counter, row, col, snapshot = 0.
  - o_busy, o_valid, o_last, o_done = 0; o_data, o_scale, o_row, o_col = 0.
- States: IDLE, WAIT, STREAM.
- IDLE:
  - i_start=1 at edge E0 → WAIT; counter ← latency-1.
- WAIT:
  - If counter==0, at that edge capture all of C_in/S_C_in into the snapshot, set row=col=0, go to STREAM.
  - Otherwise counter decrements.
  - Result: capture occurs exactly at edge E_latency.
- STREAM:
  - o_valid=1.
  - o_data/o_scale = snapshot[row][col]; o_row/o_col = row/col.
  - o_last = (row==x_rows-1 && col==y_cols-1).
  - Handshake = o_valid && i_ready.
  - On handshake: col increments; at col==y_cols-1, col←0 and row increments.
  - While i_ready=0, all outputs hold stable.
  - On handshake with o_last: go to IDLE; o_done=1 for the next cycle only.
- Timing:
  - First o_valid appears in the cycle after capture.
  - With i_ready held high, x_rows*y_cols consecutive elements are transferred.
  - o_done pulses one cycle after the last element.
- o_data, o_scale, o_row, o_col, o_last are driven 0 whenever o_valid=0.
- o_busy=1 in WAIT and STREAM.
- i_start while in WAIT or STREAM is ignored, except as below.
- Simultaneous final handshake and i_start: accepted. Next state is WAIT with counter ← latency-1. o_done still pulses. The snapshot is retained until the new capture.
- Snapshot isolation: C_in/S_C_in changes after capture do not affect streamed values.
- Reset mid-WAIT or mid-STREAM: immediate return to the reset values; no o_done; the partial transfer is abandoned.
- Widths:
  - o_data is a bit-exact copy of C_in elements (no rounding or sign change).
  - o_scale is a bit-exact copy of S_C_in.

Test Plan:
- Basic stream:
  - Stimulus: defaults; C_in[r][c]=r*4+c, S_C_in[r][c]=0x80+r; i_start at cycle 10; i_ready=1.
  - Response: capture at edge 12; 16 consecutive valids from cycle 13 with data 0..15 and scale 0x80..0x83 per row; o_last on element 15; o_done at cycle 29.
- Backpressure:
  - Stimulus: as basic, with i_ready toggling 1,0,0,1 repeating.
  - Response: data/row/col stable while i_ready=0; exactly 16 handshakes, in order; no duplicates or skips.
- Snapshot isolation and signedness:
  - Stimulus: C_in[0][0]=-128 (0x80); after capture, drive C_in to all 0x7F.
  - Response: first element -128; all streamed values equal the pre-change matrix.
- Start collisions:
  - Stimulus: i_start during STREAM.
  - Response: ignored (16 elements, single o_done).
  - Stimulus: i_start on the final-handshake cycle.
  - Response: o_done pulses; o_busy stays 1; second capture after latency; second 16-element burst.
- Reset mid-stream:
  - Stimulus: deassert i_rst_n after element 5.
  - Response: all outputs 0 immediately, with no clock needed; no o_done; a fresh i_start restarts from element (0,0).
- Parameter corner:
  - Stimulus: x_rows=1, y_cols=3, latency=1.
  - Response: capture one edge after start; 3 elements; o_last on col 2; row stays 0.
